ahb_slv_bridge: RTL

//  Parametrised AHB-Lite slave to register-bus bridge. Successor to the fixed 32b/10b slave.

---
 rtl/ahb_slv_bridge.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_slv_bridge.sv
// ---------------------------------------------------------------------------
// ahb_slv_bridge
//
// AHB-Lite slave that turns bus transfers into a simple register-bus access.
// It is placed between the AHB interconnect and the AudioNet control/status
// register file.
//
// The address phase is registered, and the register access runs in the data
// phase that follows. Byte strobes are derived from hsize and the low address
// bits. SEQ beats are checked against the address the burst should produce
// next. Range, alignment, size and burst-address violations get the two-cycle
// AHB ERROR response, and no register access is made for them. A data phase
// that waits on 'ready' for TIMEOUT cycles is also turned into an ERROR.
//
// Parameters
//   DATA_W   bus data width (32 or 64); NB = DATA_W/8 byte lanes
//   ADDR_W   register-space byte-address width; haddr[31:ADDR_W] must be 0
//   TIMEOUT  data-phase wait cycles allowed before ERROR (0 = no timeout)
//
// Ports
//   hclk, hreset          clock, asynchronous active-high reset
//   hsel, haddr, hburst,  AHB address-phase controls
//   hsize, htrans, hwrite
//   hwdata                AHB data-phase write data
//   hreadyin              bus-wide HREADY (previous transfer complete)
//   hrdata, hreadyout,    AHB slave response
//   hresp
//   val, addr, write,     register-bus request (valid during the data phase)
//   wdata, wstrb
//   rdata, ready          register-bus response
// ---------------------------------------------------------------------------
module ahb_slv_bridge #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic                hsel,
    input  logic [31:0]         haddr,
    input  logic [2:0]          hburst,
    input  logic [2:0]          hsize,
    input  logic [1:0]          htrans,
    input  logic                hwrite,
    input  logic [DATA_W-1:0]   hwdata,
    input  logic                hreadyin,
    output logic [DATA_W-1:0]   hrdata,
    output logic                hreadyout,
    output logic [1:0]          hresp,
    output logic                val,
    output logic [ADDR_W-1:0]   addr,
    output logic                write,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                ready
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    // The timer only needs to reach TIMEOUT-1 before the error is raised.
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] HTRANS_SEQ = 2'b11;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t             state_reg, state_next;

    logic [ADDR_W-1:0]  addr_reg;
    logic               write_reg;
    logic [NB-1:0]      strb_reg;
    logic [ADDR_W-1:0]  exp_addr_reg;
    logic [TMR_W-1:0]   timer_reg;

    logic [ADDR_W-1:0]  exp_addr_next;
    logic [NB-1:0]      strb_next;

    // ------------------------------------------------------------------
    // Next beat address of a burst. WRAP bursts keep the bits above the
    // wrap block fixed and let only the bits inside the block increment.
    // INCR and SINGLE simply increment, truncated to ADDR_W.
    // ------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] next_beat(
        input logic [ADDR_W-1:0] cur,
        input logic [2:0]        size,
        input logic [2:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] span;
        logic [ADDR_W-1:0] mask;
        step = {{(ADDR_W-1){1'b0}}, 1'b1} << size;
        inc  = cur + step;
        case (burst)
            HBURST_WRAP4:  span = step << 2;
            HBURST_WRAP8:  span = step << 3;
            HBURST_WRAP16: span = step << 4;
            default:       span = '0;
        endcase
        if (span == '0) begin
            next_beat = inc;
        end else begin
            mask      = span - {{(ADDR_W-1){1'b0}}, 1'b1};
            next_beat = (cur & ~mask) | (inc & mask);
        end
    endfunction

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic accept_window;
    logic accept;
    logic viol_range;
    logic viol_align;
    logic viol_size;
    logic viol_seq;
    logic viol;
    logic load_phase;
    logic timeout_hit;

    // A new address phase can be taken whenever this slave is not holding
    // the bus: in IDLE, in the second ERROR cycle, or when the current
    // access completes. The last case gives zero-bubble back-to-back transfers.
    assign accept_window = (state_reg == S_IDLE) || (state_reg == S_ERR2) ||
                           ((state_reg == S_ACCESS) && ready);
    assign accept        = accept_window && hsel && hreadyin && htrans[1];

    assign viol_range = |haddr[31:ADDR_W];
    assign viol_align = |(haddr & ((32'd1 << hsize) - 32'd1));
    assign viol_size  = (hsize > 3'(LANE_W));
    assign viol_seq   = (htrans == HTRANS_SEQ) && (haddr[ADDR_W-1:0] != exp_addr_reg);
    assign viol       = viol_range || viol_align || viol_size || viol_seq;
    assign load_phase = accept && !viol;

    assign timeout_hit = (TIMEOUT != 0) && (timer_reg == TMR_W'(TIMEOUT - 1));

    assign exp_addr_next = next_beat(haddr[ADDR_W-1:0], hsize, hburst);

    // ------------------------------------------------------------------
    // Byte strobes: lanes [lane_lo, lane_hi) are enabled. lane_hi only
    // overflows for sizes wider than the bus, and those transfers are
    // rejected as violations, so the overflow never reaches the outputs.
    // ------------------------------------------------------------------
    logic [LANE_W:0] lane_lo;
    logic [LANE_W:0] lane_hi;

    assign lane_lo = {1'b0, haddr[LANE_W-1:0]};
    assign lane_hi = lane_lo + ({{LANE_W{1'b0}}, 1'b1} << hsize);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            localparam logic [LANE_W:0] LANE_IDX = gi;
            assign strb_next[gi] = (LANE_IDX >= lane_lo) && (LANE_IDX < lane_hi);
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        hreadyout  = 1'b1;
        hresp      = RESP_OKAY;
        hrdata     = '0;
        val        = 1'b0;
        addr       = '0;
        write      = 1'b0;
        wdata      = '0;
        wstrb      = '0;

        case (state_reg)
            S_IDLE, S_ERR2: begin
                if (state_reg == S_ERR2) begin
                    hresp = RESP_ERROR;
                end
                if (accept) begin
                    state_next = viol ? S_ERR1 : S_ACCESS;
                end else begin
                    state_next = S_IDLE;
                end
            end

            S_ACCESS: begin
                val       = 1'b1;
                addr      = addr_reg;
                write     = write_reg;
                wstrb     = strb_reg;
                wdata     = write_reg ? hwdata : '0;
                hreadyout = ready;
                if (ready && !write_reg) begin
                    hrdata = rdata;
                end
                if (ready) begin
                    if (accept) begin
                        state_next = viol ? S_ERR1 : S_ACCESS;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (timeout_hit) begin
                    // Give up on the register file. val drops because the
                    // next state is ERR1.
                    state_next = S_ERR1;
                end
            end

            S_ERR1: begin
                hreadyout  = 1'b0;
                hresp      = RESP_ERROR;
                state_next = S_ERR2;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered address phase, burst tracking and wait-state timer.
    // The expected burst address changes only on a valid accept, so BUSY
    // beats and rejected beats leave it as it was.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            addr_reg     <= '0;
            write_reg    <= 1'b0;
            strb_reg     <= '0;
            exp_addr_reg <= '0;
            timer_reg    <= '0;
        end else begin
            if (load_phase) begin
                addr_reg     <= haddr[ADDR_W-1:0];
                write_reg    <= hwrite;
                strb_reg     <= strb_next;
                exp_addr_reg <= exp_addr_next;
            end
            if ((state_reg == S_ACCESS) && !ready && !timeout_hit) begin
                timer_reg <= timer_reg + 1'b1;
            end else begin
                timer_reg <= '0;
            end
        end
    end

endmodule
